// File: rtl/pic_param_ctrl.sv
// pic_param_ctrl -- programmable interrupt controller.
//
// Collects NUM_IRQ asynchronous request lines, prioritises them (fixed or
// rotating), raises INT towards the CPU and returns VBASE+line on acknowledge.
//
// Ports
//   CLK, RST_N      clock (rising edge) / async active-low reset
//   IR              asynchronous request lines, active-high
//   CS, WR, RD, A   active-low register strobes and 3-bit address
//   DIN, DOUT       32-bit write data / registered read data
//   INTA            interrupt acknowledge, active-low (falling edge acts)
//   INT             interrupt request to CPU
//   VEC, VEC_VALID  acknowledged vector and its one-cycle qualifier
//
// Register map: 0 IMR, 1 TMR, 2 CFG {VBASE[VEC_W+7:8], AEOI, ROT},
//               3 CMD (write-only EOI), 4 IRR, 5 ISR, 6/7 read as zero.
module pic_param_ctrl #(
    parameter int NUM_IRQ = 16,
    parameter int VEC_W   = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_IRQ-1:0] IR,
    input  logic               CS,
    input  logic               WR,
    input  logic               RD,
    input  logic [2:0]         A,
    input  logic [31:0]        DIN,
    output logic [31:0]        DOUT,
    input  logic               INTA,
    output logic               INT,
    output logic [VEC_W-1:0]   VEC,
    output logic               VEC_VALID
);

    localparam int                 PW   = $clog2(NUM_IRQ);
    localparam logic [NUM_IRQ-1:0] ONE  = NUM_IRQ'(1);
    localparam logic [PW-1:0]      LAST = PW'(NUM_IRQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

    // Rank of the first set bit of v counting from line 'start' upward with
    // wrap; rank 0 is the highest priority, NUM_IRQ means no bit set.
    function automatic int first_rank(input logic [NUM_IRQ-1:0] v, input int start);
        logic [2*NUM_IRQ-1:0] dbl;
        int                   r;
        dbl = {v, v} >> start;
        r   = NUM_IRQ;
        for (int j = NUM_IRQ - 1; j >= 0; j--) begin
            if (dbl[j]) r = j;
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] rank_to_idx(input int start, input int rank);
        int s;
        s = start + rank;
        if (s >= NUM_IRQ) s = s - NUM_IRQ;
        return PW'(s);
    endfunction

    // State
    logic [NUM_IRQ-1:0] ir_s1_q, irs_q, irs_prev_q;
    logic [NUM_IRQ-1:0] irr_q, irr_d;
    logic [NUM_IRQ-1:0] imr_q, imr_d;
    logic [NUM_IRQ-1:0] tmr_q, tmr_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic               rot_q, rot_d;
    logic               aeoi_q, aeoi_d;
    logic [VEC_W-1:0]   vbase_q, vbase_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic               inta_prev_q;
    logic [31:0]        dout_q, dout_d;
    state_t             state_q;
    logic               int_q;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               vec_valid_q;

    // Combinational helpers
    logic [NUM_IRQ-1:0] irr_eff, pend, eoi_clr, ack_mask;
    logic [PW-1:0]      eff_ptr, win_idx, isr_hi_idx, eoi_line;
    int                 start, pend_rank, isr_rank;
    logic               int_cond, ack_take, ack_valid, wr_en, rd_en;
    logic [31:0]        rd_val;
    logic               din_unused;

    assign din_unused = ^DIN;

    // Level-mode lines follow the synchronised input directly; edge-mode
    // lines use the latched request.
    assign irr_eff = (tmr_q & irs_q) | (~tmr_q & irr_q);

    always_comb begin
        wr_en   = !CS && !WR;
        rd_en   = !CS && !RD && WR;
        eff_ptr = rot_q ? ptr_q : LAST;
        start   = int'(eff_ptr) + 1;
        if (start >= NUM_IRQ) start = 0;

        pend       = irr_eff & ~imr_q;
        pend_rank  = first_rank(pend, start);
        isr_rank   = first_rank(isr_q, start);
        // A pending line must strictly outrank everything in service.
        int_cond   = pend_rank < isr_rank;
        win_idx    = rank_to_idx(start, pend_rank);
        isr_hi_idx = rank_to_idx(start, isr_rank);

        ack_take  = inta_prev_q && !INTA && (state_q != S_ACK);
        ack_valid = ack_take && int_cond;
        ack_mask  = ack_valid ? (ONE << win_idx) : '0;
        vec_d     = ack_valid ? (vbase_q + VEC_W'(win_idx))
                              : (vbase_q + VEC_W'(NUM_IRQ - 1));

        // EOI decode; out-of-range or idle lines shift to an empty mask.
        eoi_clr  = '0;
        eoi_line = '0;
        if (wr_en && A == 3'd3) begin
            if (DIN[5]) begin
                eoi_clr  = isr_q & (ONE << DIN[4:0]);
                eoi_line = PW'(DIN[4:0]);
            end else if (isr_rank < NUM_IRQ) begin
                eoi_clr  = ONE << isr_hi_idx;
                eoi_line = isr_hi_idx;
            end
        end

        // EOI clears first, then the acknowledge sets its bit.
        isr_d = (isr_q & ~eoi_clr) | (aeoi_q ? '0 : ack_mask);
        irr_d = ((irr_q & ~ack_mask) | (irs_q & ~irs_prev_q)) & ~tmr_q;

        ptr_d = ptr_q;
        if (rot_q && |eoi_clr)              ptr_d = eoi_line;
        if (rot_q && aeoi_q && ack_valid)   ptr_d = win_idx;

        imr_d   = imr_q;
        tmr_d   = tmr_q;
        rot_d   = rot_q;
        aeoi_d  = aeoi_q;
        vbase_d = vbase_q;
        if (wr_en) begin
            case (A)
                3'd0: imr_d = DIN[NUM_IRQ-1:0];
                3'd1: tmr_d = DIN[NUM_IRQ-1:0];
                3'd2: begin
                    rot_d   = DIN[0];
                    aeoi_d  = DIN[1];
                    vbase_d = DIN[VEC_W+7:8];
                end
                default: ;
            endcase
        end

        rd_val = '0;
        case (A)
            3'd0: rd_val[NUM_IRQ-1:0] = imr_q;
            3'd1: rd_val[NUM_IRQ-1:0] = tmr_q;
            3'd2: begin
                rd_val[0]           = rot_q;
                rd_val[1]           = aeoi_q;
                rd_val[VEC_W+7:8]   = vbase_q;
            end
            3'd4: rd_val[NUM_IRQ-1:0] = irr_eff;
            3'd5: rd_val[NUM_IRQ-1:0] = isr_q;
            default: ;
        endcase
        dout_d = rd_en ? rd_val : dout_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ir_s1_q     <= '0;
            irs_q       <= '0;
            irs_prev_q  <= '0;
            irr_q       <= '0;
            imr_q       <= '1;
            tmr_q       <= '0;
            isr_q       <= '0;
            rot_q       <= 1'b0;
            aeoi_q      <= 1'b0;
            vbase_q     <= '0;
            ptr_q       <= LAST;
            inta_prev_q <= 1'b1;
            dout_q      <= '0;
        end else begin
            ir_s1_q     <= IR;
            irs_q       <= ir_s1_q;
            irs_prev_q  <= irs_q;
            irr_q       <= irr_d;
            imr_q       <= imr_d;
            tmr_q       <= tmr_d;
            isr_q       <= isr_d;
            rot_q       <= rot_d;
            aeoi_q      <= aeoi_d;
            vbase_q     <= vbase_d;
            ptr_q       <= ptr_d;
            inta_prev_q <= INTA;
            dout_q      <= dout_d;
        end
    end

    // Acknowledge sequencer with registered INT / VEC / VEC_VALID.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            int_q       <= 1'b0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
        end else begin
            vec_valid_q <= 1'b0;
            if (ack_take) begin
                state_q     <= S_ACK;
                int_q       <= 1'b0;
                vec_q       <= vec_d;
                vec_valid_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: if (int_cond) begin
                        state_q <= S_REQ;
                        int_q   <= 1'b1;
                    end
                    S_REQ: if (!int_cond) begin
                        state_q <= S_IDLE;
                        int_q   <= 1'b0;
                    end
                    S_ACK: begin
                        state_q <= S_IDLE;
                        int_q   <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        int_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DOUT      = dout_q;
    assign INT       = int_q;
    assign VEC       = vec_q;
    assign VEC_VALID = vec_valid_q;

endmodule

// File: tb/tb_pic_param_ctrl.sv
// Bench for pic_param_ctrl: scenario tasks drive the bus/IR/INTA, expected
// vectors go into a queue that a monitor pops on every VEC_VALID pulse.
module tb_pic_param_ctrl;
    localparam int N  = 16;
    localparam int VW = 8;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic [N-1:0]  IR = '0;
    logic          CS = 1'b1, WR = 1'b1, RD = 1'b1;
    logic [2:0]    A = '0;
    logic [31:0]   DIN = '0;
    logic [31:0]   DOUT;
    logic          INTA = 1'b1;
    logic          INT;
    logic [VW-1:0] VEC;
    logic          VEC_VALID;

    int            errors = 0;
    int            checks = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] mon_exp;
    logic [31:0]   rdat;

    pic_param_ctrl #(.NUM_IRQ(N), .VEC_W(VW)) dut (
        .CLK(CLK), .RST_N(RST_N), .IR(IR), .CS(CS), .WR(WR), .RD(RD),
        .A(A), .DIN(DIN), .DOUT(DOUT), .INTA(INTA), .INT(INT),
        .VEC(VEC), .VEC_VALID(VEC_VALID)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every vector pulse must match the oldest expectation.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && VEC_VALID === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL vec_unexpected: got VEC=%h, no vector expected", VEC);
            end else begin
                mon_exp = exp_q.pop_front();
                if (VEC !== mon_exp) begin
                    errors++;
                    $display("FAIL vec_scoreboard: got %h expected %h", VEC, mon_exp);
                end
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        CS = 1; WR = 1; RD = 1; INTA = 1; IR = '0;
        RST_N = 0;
        tick; tick;
        RST_N = 1;
        exp_q.delete();
        tick;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        CS = 0; WR = 0; A = a; DIN = d;
        tick;
        CS = 1; WR = 1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        CS = 0; RD = 0; A = a;
        tick;
        CS = 1; RD = 1;
        d = DOUT;
    endtask

    task automatic wait_int(input string name);
        int n;
        n = 0;
        while (INT !== 1'b1 && n < 10) begin
            tick;
            n++;
        end
        checks++;
        if (INT !== 1'b1) begin
            errors++;
            $display("FAIL %s: INT=%b after %0d cycles, required 1", name, INT, n);
        end
    endtask

    task automatic expect_int_low(input string name, input int cycles);
        repeat (cycles) tick;
        checks++;
        if (INT !== 1'b0) begin
            errors++;
            $display("FAIL %s: INT=%b required 0", name, INT);
        end
    endtask

    task automatic do_ack(input logic [VW-1:0] v, input string name);
        exp_q.push_back(v);
        INTA = 0;
        tick;
        checks++;
        if (VEC_VALID !== 1'b1 || VEC !== v || INT !== 1'b0) begin
            errors++;
            $display("FAIL %s: VEC_VALID=%b VEC=%h INT=%b required 1/%h/0",
                     name, VEC_VALID, VEC, INT, v);
        end
        INTA = 1;
        tick;
        checks++;
        if (VEC_VALID !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pulse: VEC_VALID=%b pending=%0d required 0/0",
                     name, VEC_VALID, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic expect_rd(input logic [2:0] a, input logic [31:0] e, input string name);
        rd(a, rdat);
        checks++;
        if (rdat !== e) begin
            errors++;
            $display("FAIL %s: read A=%0d got %h expected %h", name, a, rdat, e);
        end
    endtask

    task automatic test_reset;
        #2 RST_N = 0;
        #2;
        checks++;
        if (DOUT !== 32'h0 || INT !== 1'b0 || VEC !== '0 || VEC_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: DOUT=%h INT=%b VEC=%h VV=%b required all 0",
                     DOUT, INT, VEC, VEC_VALID);
        end
        tick; tick;
        RST_N = 1;
        tick;
        expect_rd(3'd0, 32'h0000_FFFF, "reset_imr");
        expect_rd(3'd1, 32'h0, "reset_tmr");
        expect_rd(3'd2, 32'h0, "reset_cfg");
        expect_rd(3'd4, 32'h0, "reset_irr");
        expect_rd(3'd5, 32'h0, "reset_isr");
    endtask

    task automatic test_regs;
        do_reset;
        wr(3'd1, 32'hFFFF_00F0);
        expect_rd(3'd1, 32'h0000_00F0, "tmr_upper_bits");
        wr(3'd1, 32'h0);
        wr(3'd7, 32'hFFFF_FFFF);
        expect_rd(3'd7, 32'h0, "addr7_reads_zero");
        expect_rd(3'd3, 32'h0, "cmd_reads_zero");
        expect_rd(3'd0, 32'h0000_FFFF, "imr_read");
        repeat (3) tick;
        checks++;
        if (DOUT !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL dout_hold: got %h expected 0000ffff", DOUT);
        end
        wr(3'd2, 32'hFFFF_FFFF);
        expect_rd(3'd2, 32'h0000_FF03, "cfg_readback");
    endtask

    task automatic test_basic;
        do_reset;
        wr(3'd2, 32'h0000_D800);
        wr(3'd0, 32'h0000_FFFE);
        IR[0] = 1; tick; tick; IR[0] = 0;
        wait_int("basic_int");
        do_ack(8'hD8, "basic_ack");
        expect_rd(3'd5, 32'h0000_0001, "basic_isr");
        expect_rd(3'd4, 32'h0, "basic_irr");
    endtask

    task automatic test_fixed_prio;
        do_reset;
        wr(3'd2, 32'h0000_4000);
        wr(3'd0, 32'h0);
        IR[3] = 1; IR[7] = 1;
        wait_int("fixed_int");
        do_ack(8'h43, "fixed_ack3");
        expect_int_low("fixed_no_int_lower", 5);
        expect_rd(3'd4, 32'h0000_0080, "fixed_irr");
        wr(3'd3, 32'h0);
        wait_int("fixed_int2");
        do_ack(8'h47, "fixed_ack7");
        expect_rd(3'd5, 32'h0000_0080, "fixed_isr");
        IR = '0;
    endtask

    task automatic test_spurious;
        do_reset;
        wr(3'd2, 32'h0000_2000);
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0000_0001);
        IR[0] = 1;
        wait_int("spur_int");
        IR[0] = 0;
        expect_int_low("spur_int_drop", 4);
        do_ack(8'h2F, "spur_ack");
        expect_rd(3'd5, 32'h0, "spur_isr");
    endtask

    task automatic test_rotate;
        do_reset;
        wr(3'd2, 32'h0000_6001);
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0000_0003);
        IR[1:0] = 2'b11;
        wait_int("rot_int0");
        do_ack(8'h60, "rot_ack0");
        expect_int_low("rot_no_int_line1", 3);
        wr(3'd3, 32'h0);
        wait_int("rot_int1");
        do_ack(8'h61, "rot_ack1");
        wr(3'd3, 32'h0);
        wait_int("rot_int2");
        do_ack(8'h60, "rot_ack0_again");
        IR = '0;
    endtask

    task automatic test_nesting;
        do_reset;
        wr(3'd2, 32'h0000_8000);
        wr(3'd0, 32'h0);
        IR[5] = 1;
        wait_int("nest_int5");
        do_ack(8'h85, "nest_ack5");
        IR[9] = 1;
        expect_int_low("nest_lower_blocked", 5);
        IR[2] = 1;
        wait_int("nest_int2");
        do_ack(8'h82, "nest_ack2");
        expect_rd(3'd5, 32'h0000_0024, "nest_isr_both");
        wr(3'd3, 32'h0000_0022);
        expect_rd(3'd5, 32'h0000_0020, "nest_spec_eoi");
        wr(3'd3, 32'h0);
        wait_int("nest_int9");
        do_ack(8'h89, "nest_ack9");
        IR = '0;
    endtask

    task automatic test_irr_read;
        do_reset;
        wr(3'd0, 32'h0000_0001);
        IR[0] = 1; IR[3] = 1; IR[7] = 1;
        repeat (5) tick;
        expect_rd(3'd4, 32'h0000_0089, "irr_read");
        IR = '0;
    endtask

    task automatic test_aeoi;
        do_reset;
        wr(3'd2, 32'h0000_1002);
        wr(3'd0, 32'h0);
        IR[4] = 1;
        wait_int("aeoi_int");
        do_ack(8'h14, "aeoi_ack");
        expect_rd(3'd5, 32'h0, "aeoi_isr_empty");
        IR = '0;
    endtask

    // IMR write lands in the acknowledge cycle; the acknowledge must see the
    // old mask.
    task automatic test_back_to_back;
        do_reset;
        wr(3'd2, 32'h0000_A000);
        wr(3'd0, 32'h0);
        IR[6] = 1;
        wait_int("b2b_int");
        CS = 0; WR = 0; A = 3'd0; DIN = 32'h0000_FFFF;
        do_ack(8'hA6, "b2b_ack");
        CS = 1; WR = 1;
        expect_rd(3'd5, 32'h0000_0040, "b2b_isr");
        expect_rd(3'd0, 32'h0000_FFFF, "b2b_imr");
        IR = '0;
    endtask

    task automatic test_reset_abort;
        do_reset;
        wr(3'd0, 32'h0);
        IR[1] = 1;
        wait_int("abort_int");
        INTA = 0;
        #2 RST_N = 0;
        tick; tick;
        checks++;
        if (VEC_VALID !== 1'b0 || INT !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_pulse: VEC_VALID=%b INT=%b required 0/0", VEC_VALID, INT);
        end
        INTA = 1; IR = '0;
        RST_N = 1;
        tick;
        expect_rd(3'd0, 32'h0000_FFFF, "abort_imr_reset");
    endtask

    initial begin
        test_reset;
        test_regs;
        test_basic;
        test_fixed_prio;
        test_spurious;
        test_rotate;
        test_nesting;
        test_irr_read;
        test_aeoi;
        test_back_to_back;
        test_reset_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
